id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register for the 5-stage pipeline, with integrated load-use hazard detection and bubble insertion. It captures decoded operands and control from ID and presents the registered `ie_rs`, `ie_rt`, `ie_registertowrite` and control fields to EX. The forwarding unit consumes those fields directly. On a load-use dependency it stalls PC and IF/ID for exactly one cycle and injects a bubble. Saturating counters give stall and flush statistics.

## Interface
- `DATA_W`, 32, operand/immediate width
- `CNT_W`, 16, statistics counter width
- `clk_i` in 1: clock, rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `id_valid` in 1: ID holds a real instruction
- `id_rs`, `id_rt`, `id_rd` in 5 each: register specifiers from decode
- `id_rs_data`, `id_rt_data` in DATA_W: register file read data
- `id_imm` in DATA_W: sign-extended immediate
- `id_regwrite`, `id_memread`, `id_memwrite`, `id_memtoreg`, `id_alusrc`, `id_regdst` in 1 each: decoded control
- `id_aluctrl` in 4: ALU operation
- `wb_regwrite` in 1, `wb_rd` in 5, `wb_data` in DATA_W: write port of the WB stage
- `flush_i` in 1: branch/jump resolved taken in EX; kill the instruction in ID
- `stall_o` out 1: hold PC and IF/ID this cycle
- `ie_valid` out 1; `ie_rs`, `ie_rt`, `ie_registertowrite` out 5 each
- `ie_rs_data`, `ie_rt_data`, `ie_imm` out DATA_W
- `ie_regwrite`, `ie_memread`, `ie_memwrite`, `ie_memtoreg`, `ie_alusrc` out 1 each; `ie_aluctrl` out 4
- `stall_cnt`, `flush_cnt` out CNT_W

## Operation
- **Hazard term.** `use_rt = !id_alusrc || id_memwrite`. The raw hazard is `ie_valid && ie_memread && ie_registertowrite!=0 && (ie_registertowrite==id_rs || (use_rt && ie_registertowrite==id_rt)) && id_valid`.
- **`stall_o`** = hazard && !flush_i. It is combinational from registered ID/EX state plus the ID inputs.
- **Per-edge priority:** flush_i, then stall_o, then capture.
  - **Flush or stall:** load a bubble. `ie_valid`, `ie_regwrite`, `ie_memread`, `ie_memwrite`, `ie_memtoreg` go to 0. `ie_registertowrite` goes to 0. Datapath fields may keep any value.
  - **Capture:** all `ie_*` take the `id_*` values. `ie_valid` = id_valid.
  - **Capture with `id_valid`=0:** write-type controls are forced to 0, so an invalid slot never writes.
- **Destination select:** `ie_registertowrite` = id_regdst ? id_rd : id_rt.
- **WB write-through on capture:**
  - If wb_regwrite && wb_rd!=0 && wb_rd==id_rs, then `ie_rs_data` = wb_data.
  - The same rule applies independently for rt and `ie_rt_data`.
  - Register 0 is never bypassed.
- **Stall length:** exactly one cycle per load-use pair. The next cycle has a bubble in ID/EX, so the hazard term is false and the dependent instruction is captured. Its operand is then forwarded from MEM/WB.
- **Counters:**
  - `stall_cnt` +1 on each cycle where `stall_o`=1.
  - `flush_cnt` +1 on each cycle where `flush_i`=1.
  - Both saturate at all-ones; no wrap.

## Timing
- **Reset (rst_n=0, asynchronous):**
  - All `ie_*` outputs 0, including `ie_valid`=0.
  - Counters 0.
  - `stall_o`=0, because it follows from `ie_valid`=0.
- **Reset release:** the first capture happens on the first rising edge with rst_n=1.
- **Latency:** 1 cycle from ID inputs to `ie_*` outputs.
- **`stall_o` timing:** valid in the same cycle as the ID inputs it depends on; there is no registered delay.
- **Flush and stall in the same cycle:** the flush wins. `stall_o`=0, a bubble is inserted, and `flush_cnt` increments while `stall_cnt` does not.
- **Reset asserted mid-stall:** outputs clear immediately. The stall does not resume after reset.
- **Back-to-back loads:** each dependent consumer causes its own single stall.
- **Load whose destination is r0:** never stalls.

## Test plan
- **Load-use on rs.** Cycle n: capture lw with memread=1, regdst=0, rt=5. Cycle n+1: ID add with rs=5. Required: stall_o=1 in n+1; at the n+2 edge ie_valid=0 and ie_regwrite=0; in n+2 stall_o=0 and the add is captured at the n+3 edge; stall_cnt=1.
- **Store rt dependency vs. immediate.** After a lw to r7: a sw with rt=7 (alusrc=1, memwrite=1) must stall. An addi with rt=7 (alusrc=1, memwrite=0) must not stall.
- **Flush priority.** A load-use condition with flush_i=1 in the same cycle gives stall_o=0, a bubble captured, flush_cnt=1 and stall_cnt=0.
- **WB write-through.** id_rs=3, id_rs_data=0x11, wb_regwrite=1, wb_rd=3, wb_data=0xABCD gives ie_rs_data=0xABCD. The same stimulus with wb_rd=0 and id_rs=0 gives ie_rs_data=id_rs_data.
- **Reset mid-operation.** Assert rst_n=0 while ie_valid=1 and stall_o=1. Without any clock edge, all outputs and counters read 0 and stall_o=0.
- **Counter saturation.** Preload by forcing 2^CNT_W−1 stall cycles; a further stall leaves stall_cnt=0xFFFF.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
//
// Captures decoded operands and control from ID every cycle and presents
// them to EX one cycle later. When the instruction in EX is a load whose
// destination is read by the instruction in ID, stall_o holds PC and IF/ID
// for one cycle while a bubble is loaded here. A taken branch/jump
// (flush_i) kills the ID instruction, also by loading a bubble.
//
// Ports:
//   clk_i, rst_n         clock (rising edge), async active-low reset
//   id_*                 decoded instruction from ID
//   wb_regwrite/rd/data  WB write port, bypassed into captured operands
//   flush_i              kill the instruction currently in ID
//   stall_o              combinational load-use stall request
//   ie_*                 registered ID/EX fields consumed by EX/forwarding
//   stall_cnt/flush_cnt  saturating event counters
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic [3:0]        id_aluctrl,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ie_valid,
  output logic [4:0]        ie_rs,
  output logic [4:0]        ie_rt,
  output logic [4:0]        ie_registertowrite,
  output logic [DATA_W-1:0] ie_rs_data,
  output logic [DATA_W-1:0] ie_rt_data,
  output logic [DATA_W-1:0] ie_imm,
  output logic              ie_regwrite,
  output logic              ie_memread,
  output logic              ie_memwrite,
  output logic              ie_memtoreg,
  output logic              ie_alusrc,
  output logic [3:0]        ie_aluctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              valid_q, valid_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, rtw_q, rtw_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic              regwrite_q, regwrite_d, memread_q, memread_d;
  logic              memwrite_q, memwrite_d, memtoreg_q, memtoreg_d;
  logic              alusrc_q, alusrc_d;
  logic [3:0]        aluctrl_q, aluctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic use_rt;
  logic hazard;
  logic stall;
  logic bubble;

  // Load-use detection: rt only matters when it is a source (R-type or store data).
  always_comb begin
    use_rt = !id_alusrc || id_memwrite;
    hazard = valid_q && memread_q && (rtw_q != 5'd0) &&
             ((rtw_q == id_rs) || (use_rt && (rtw_q == id_rt))) && id_valid;
    stall  = hazard && !flush_i;
    bubble = flush_i || stall;
  end

  // Next ID/EX contents: datapath always loads, control is cleared on bubble or invalid slot.
  always_comb begin
    rs_d      = id_rs;
    rt_d      = id_rt;
    imm_d     = id_imm;
    alusrc_d  = id_alusrc;
    aluctrl_d = id_aluctrl;
    // A result being written back this cycle is newer than the register file read.
    if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rs)) begin
      rs_data_d = wb_data;
    end else begin
      rs_data_d = id_rs_data;
    end
    if (wb_regwrite && (wb_rd != 5'd0) && (wb_rd == id_rt)) begin
      rt_data_d = wb_data;
    end else begin
      rt_data_d = id_rt_data;
    end
    if (!bubble && id_valid) begin
      valid_d    = 1'b1;
      regwrite_d = id_regwrite;
      memread_d  = id_memread;
      memwrite_d = id_memwrite;
      memtoreg_d = id_memtoreg;
      rtw_d      = id_regdst ? id_rd : id_rt;
    end else begin
      valid_d    = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
      memtoreg_d = 1'b0;
      rtw_d      = 5'd0;
    end
  end

  // Saturating stall/flush event counters.
  always_comb begin
    if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (flush_i && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // ID/EX state and counter registers.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      rtw_q       <= 5'd0;
      rs_data_q   <= {DATA_W{1'b0}};
      rt_data_q   <= {DATA_W{1'b0}};
      imm_q       <= {DATA_W{1'b0}};
      regwrite_q  <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      alusrc_q    <= 1'b0;
      aluctrl_q   <= 4'd0;
      stall_cnt_q <= {CNT_W{1'b0}};
      flush_cnt_q <= {CNT_W{1'b0}};
    end else begin
      valid_q     <= valid_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rtw_q       <= rtw_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      regwrite_q  <= regwrite_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      memtoreg_q  <= memtoreg_d;
      alusrc_q    <= alusrc_d;
      aluctrl_q   <= aluctrl_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_o            = stall;
  assign ie_valid           = valid_q;
  assign ie_rs              = rs_q;
  assign ie_rt              = rt_q;
  assign ie_registertowrite = rtw_q;
  assign ie_rs_data         = rs_data_q;
  assign ie_rt_data         = rt_data_q;
  assign ie_imm             = imm_q;
  assign ie_regwrite        = regwrite_q;
  assign ie_memread         = memread_q;
  assign ie_memwrite        = memwrite_q;
  assign ie_memtoreg        = memtoreg_q;
  assign ie_alusrc          = alusrc_q;
  assign ie_aluctrl         = aluctrl_q;
  assign stall_cnt          = stall_cnt_q;
  assign flush_cnt          = flush_cnt_q;

endmodule
